// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready flow control.
//
// Stage 1 registers the operands and op select on an input handshake.
// Stage 2 computes the result from the stage-1 registers and registers the
// result together with CarryOut, Zero and Overflow. A beat accepted at edge N
// is presented with out_valid = 1 after edge N+1. Backpressure from the sink
// stalls the stages without dropping or duplicating beats.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (depends on out_ready only)
//   A, B       operands, WIDTH bits
//   ALU_Sel    operation select (AND OR XOR ADD SUB NOT SHL SHR)
//   out_valid  result beat present
//   out_ready  sink accepts the result this cycle
//   ALU_Out    result, WIDTH bits
//   CarryOut   carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
//   Zero       ALU_Out == 0
//   Overflow   signed overflow for ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  alu_op_e          s1_sel_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_carry_q;
  logic             s2_zero_q;
  logic             s2_ovf_q;

  // Stage 2 next-state from the ALU
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             zero_d;
  logic             ovf_d;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // A stage may load when it is empty or its contents leave this edge.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Extra MSB of the widened sum is the carry; of the widened difference it
  // is the borrow (set exactly when A < B unsigned).
  assign sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff = {1'b0, s1_a_q} - {1'b0, s1_b_q};

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (s1_sel_q)
      OP_AND: res_d = s1_a_q & s1_b_q;
      OP_OR:  res_d = s1_a_q | s1_b_q;
      OP_XOR: res_d = s1_a_q ^ s1_b_q;
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                  (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                  (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_NOT: res_d = ~s1_a_q;
      OP_SHL: begin
        res_d   = {s1_b_q[WIDTH-2:0], 1'b0};
        carry_d = s1_b_q[WIDTH-1];
      end
      OP_SHR: begin
        res_d   = {1'b0, s1_b_q[WIDTH-1:1]};
        carry_d = s1_b_q[0];
      end
      default: ;
    endcase
    zero_d = (res_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: the stage-1 operand registers are not reset; they are only ever
  // observed through s1_valid_q, which is.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q   <= A;
        s1_b_q   <= B;
        s1_sel_q <= alu_op_e'(ALU_Sel);
      end
    end
  end

  // Stage 2 reloads whenever it may advance, even from an empty stage 1;
  // the data is then don't-care and qualified off by s2_valid_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_carry_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_res_q   <= res_d;
      s2_carry_q <= carry_d;
      s2_zero_q  <= zero_d;
      s2_ovf_q   <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign ALU_Out   = s2_res_q;
  assign CarryOut  = s2_carry_q;
  assign Zero      = s2_zero_q;
  assign Overflow  = s2_ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe.
//
// Three instances (WIDTH = 4, 8, 16) share one set of handshake inputs; each
// gets the low bits of the shared operand buses. Directed checks run against
// the 4-bit instance; a scoreboard fed by a plain-arithmetic reference model
// checks every consumed beat of every instance.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  sel;
  logic [15:0] a_drv;
  logic [15:0] b_drv;

  logic        rdy4, rdy8, rdy16;
  logic        ov4, ov8, ov16;
  logic [3:0]  out4;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic        c4, c8, c16, z4, z8, z16, v4, v8, v16;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_in[3];
  int   n_out[3];
  exp_t q4[$];
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .A(a_drv[3:0]), .B(b_drv[3:0]), .ALU_Sel(sel),
    .out_valid(ov4), .out_ready(out_ready), .ALU_Out(out4),
    .CarryOut(c4), .Zero(z4), .Overflow(v4)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .A(a_drv[7:0]), .B(b_drv[7:0]), .ALU_Sel(sel),
    .out_valid(ov8), .out_ready(out_ready), .ALU_Out(out8),
    .CarryOut(c8), .Zero(z8), .Overflow(v8)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .A(a_drv), .B(b_drv), .ALU_Sel(sel),
    .out_valid(ov16), .out_ready(out_ready), .ALU_Out(out16),
    .CarryOut(c16), .Zero(z16), .Overflow(v16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU on plain integers: mask to w bits, derive flags from signs.
  function automatic exp_t ref_alu(input int w, input logic [15:0] a_in,
                                   input logic [15:0] b_in, input logic [2:0] op);
    longint mask, a, b, r;
    bit     c, v, sa, sb, sr;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    a    = longint'(a_in) & mask;
    b    = longint'(b_in) & mask;
    sa   = a[w-1];
    sb   = b[w-1];
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin r = a + b; c = (r > mask); end
      3'd4: begin r = a - b; c = (a < b);    end
      3'd5: r = ~a;
      3'd6: begin r = b << 1; c = sb;   end
      3'd7: begin r = b >> 1; c = b[0]; end
      default: r = 0;
    endcase
    r  = r & mask;
    sr = r[w-1];
    if (op == 3'd3) v = (sa == sb) && (sr != sa);
    if (op == 3'd4) v = (sa != sb) && (sr != sa);
    e.res = 16'(r);
    e.c   = c;
    e.z   = (r == 0);
    e.v   = v;
    return e;
  endfunction

  // Scoreboard for one instance: consume first, then record a new accept.
  task automatic mon(input int idx, input logic rdy, input logic ov,
                     input logic [15:0] res, input logic c, input logic z, input logic v);
    exp_t e;
    exp_t g;
    int   w;
    w = (idx == 0) ? 4 : (idx == 1) ? 8 : 16;
    if (ov && out_ready) begin
      n_out[idx]++;
      g = '{res: res, c: c, z: z, v: v};
      if ((idx == 0 && q4.size() == 0) || (idx == 1 && q8.size() == 0) ||
          (idx == 2 && q16.size() == 0)) begin
        check($sformatf("sb_w%0d_unexpected_beat", w), 32'(ov), 32'd0);
      end else begin
        case (idx)
          0:       e = q4.pop_front();
          1:       e = q8.pop_front();
          default: e = q16.pop_front();
        endcase
        check($sformatf("sb_w%0d_beat", w), 32'(g), 32'(e));
      end
    end
    if (in_valid && rdy) begin
      n_in[idx]++;
      e = ref_alu(w, a_drv, b_drv, sel);
      case (idx)
        0:       q4.push_back(e);
        1:       q8.push_back(e);
        default: q16.push_back(e);
      endcase
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1 ns later.
  task automatic step(input logic r, input logic iv, input logic [2:0] s,
                      input logic [15:0] a, input logic [15:0] b, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    sel       = s;
    a_drv     = a;
    b_drv     = b;
    out_ready = ordy;
    #1;
    if (r) begin
      q4.delete();
      q8.delete();
      q16.delete();
      for (int k = 0; k < 3; k++) begin
        n_in[k]  = 0;
        n_out[k] = 0;
      end
    end else begin
      mon(0, rdy4,  ov4,  {12'd0, out4}, c4,  z4,  v4);
      mon(1, rdy8,  ov8,  {8'd0, out8},  c8,  z8,  v8);
      mon(2, rdy16, ov16, out16,         c16, z16, v16);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_out[8];
    logic       exp_c[8];
    int         nb;
    int         cyc;

    exp_out = '{4'b0001, 4'b0111, 4'b0110, 4'b1000, 4'b1110, 4'b1100, 4'b1010, 4'b0010};
    exp_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; a_drv = '0; b_drv = '0;

    // Reset state
    step(1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_outputs",   32'({out4, c4, z4, v4}), 32'd0);
    check("rst_in_ready",  32'(rdy4), 32'd1);
    check("rst_outputs_w16", 32'({out16, c16, z16, v16, ov16}), 32'd0);

    // All eight ops on A=0011, B=0101, back to back, sink always ready
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i < 8), 3'(i), 16'h0003, 16'h0005, 1'b1);
      check($sformatf("ops_in_ready_%0d", i), 32'(rdy4), 32'd1);
      if (i < 2) begin
        check($sformatf("ops_latency_%0d", i), 32'(ov4), 32'd0);
      end else begin
        check($sformatf("ops_valid_%0d", i - 2), 32'(ov4), 32'd1);
        check($sformatf("ops_result_%0d", i - 2), 32'({out4, c4, z4, v4}),
              32'({exp_out[i-2], exp_c[i-2], 1'b0, (i - 2 == 3)}));
      end
    end

    // Wrap-around corner cases
    step(1'b0, 1'b1, 3'd3, 16'h000F, 16'h0001, 1'b1);
    step(1'b0, 1'b1, 3'd4, 16'h0008, 16'h0001, 1'b1);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
    check("add_wrap", 32'({ov4, out4, c4, z4, v4}), 32'({1'b1, 4'b0000, 1'b1, 1'b1, 1'b0}));
    step(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
    check("sub_ovf",  32'({ov4, out4, c4, z4, v4}), 32'({1'b1, 4'b0111, 1'b0, 1'b0, 1'b1}));

    // Backpressure: six ADD beats (A=i, B=1), sink stalled for four cycles
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, (nb < 6), 3'd3, 16'(nb), 16'd1, (c >= 4));
      if (c < 4) check($sformatf("bp_in_ready_%0d", c), 32'(rdy4), 32'(c < 2));
      if (c == 2 || c == 3) check($sformatf("bp_hold_%0d", c), 32'({ov4, out4}), {27'd0, 1'b1, 4'd1});
      if (c >= 4 && c <= 9) check($sformatf("bp_drain_%0d", c), 32'({ov4, out4}), 32'({1'b1, 4'(c - 3)}));
      if (c == 10) check("bp_empty", 32'(ov4), 32'd0);
      if (in_valid && rdy4) nb++;
    end
    check("bp_accepted", 32'(nb), 32'd6);

    // Reset with both stages full and the sink stalled
    step(1'b0, 1'b1, 3'd0, 16'h0077, 16'h0077, 1'b0);
    step(1'b0, 1'b1, 3'd0, 16'h0077, 16'h0077, 1'b0);
    step(1'b0, 1'b1, 3'd0, 16'h0077, 16'h0077, 1'b0);
    check("full_in_ready", 32'({rdy4, ov4}), 32'b01);
    step(1'b1, 1'b1, 3'd0, 16'h0077, 16'h0077, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    check("midrst_outputs_w4",  32'({ov4, out4, c4, z4, v4, rdy4}), 32'd1);
    check("midrst_outputs_w16", 32'({ov16, out16, c16, z16, v16, rdy16}), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
      check($sformatf("midrst_no_ghost_%0d", k), 32'({ov4, ov8, ov16}), 32'd0);
    end

    // Random traffic, 1000 accepted beats, scoreboard against the model
    step(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    cyc = 0;
    while (n_in[0] < 1000 && cyc < 20000) begin
      step(1'b0, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("rand_beats_in", 32'(n_in[0]), 32'd1000);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rand_in_eq_out_%0d", k), 32'(n_out[k]), 32'(n_in[k]));
    end
    check("rand_queues_empty", 32'(q4.size() + q8.size() + q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
